tqvp_hx2003_pulse_receiver: RTL and testbench
=============================================

# tqvp_hx2003_pulse_receiver

TinyQV peripheral that captures a pulse train on one `ui_in` pin and classifies each pulse by level and duration into a 2-bit symbol. Symbols are packed into an 8×32-bit symbol memory with the same encoding the pulse transmitter consumes, so a captured train can be replayed unchanged. Software reads the symbols over the standard TinyQV peripheral bus. An interrupt fires when a capture completes.

## Interface
- Parameters: `NUM_DATA_REG`, default 8: symbol memory words, ≤8, 16 symbols per word.
- `clk` in 1: clock, 64 MHz nominal.
- `rst_n` in 1: reset, synchronous, active-low.
- `ui_in` in 8: input PMOD, already synchronized; the capture pin is selected by config.
- `uo_out` out 8: all bits 0.
- `address` in 6: byte address within the peripheral.
- `data_in` in 32: write data.
- `data_write_n` in 2: 11 none, 00/01/10 = 8/16/32-bit; only 10 is honored.
- `data_read_n` in 2: unused; reads are combinational.
- `data_out` out 32: read data.
- `data_ready` out 1: constant 1.
- `user_interrupt` out 1: `done & irq_en`.

## Operation
- Register map. With `address[5]`=0, `address[3:2]` selects the register. With `address[5]`=1, `address[4:2]` selects a memory word (read-only).
- CFG (0x00, R/W):
  - [0] `enable`.
  - [3:1] `pin_sel` (`ui_in` index).
  - [4] `invert`.
  - [5] `irq_en`.
  - [9:6] `prescaler` P.
  - [17:10] `idle_timeout` in ticks; 0 means 256.
  - [24:18] `last_index` (symbols captured = `last_index`+1).
- THR (0x04, R/W): [7:0] `low_threshold`, [15:8] `high_threshold`.
- STATUS (0x08):
  - Read: [6:0] `symbol_count`, [8] `done`, [9] `overflow`, [10] `busy`, [11] current level.
  - Write: bit8=1 clears `done`.
- Level definition: `lvl = ui_in[pin_sel] ^ invert`. Idle level is 0.
- Tick generation: a free-running prescale counter, reset at each edge, produces one tick every 2^P clk.
- Duration counter: 8-bit, increments per tick, saturates at 255. Saturation while `lvl`=1 sets `overflow`.
- Symbol encoding on each edge ending a pulse:
  - symbol = {`prev_lvl`, `dur > thr[prev_lvl]`}, where `thr[0]` = `low_threshold` and `thr[1]` = `high_threshold`.
  - The symbol is written at bits [2k+1:2k] of word k>>4, with k = `symbol_count`.
- FSM:
  - IDLE: `enable`=0. Holds the results.
  - ARMED: waits for the first 0→1 edge, which starts the first pulse. No symbol is recorded for the leading idle period.
  - MEASURE:
    - Every edge records a symbol and increments `symbol_count`.
    - The write where k = `last_index` goes to DONE.
    - When `lvl`=0 and `dur` reaches `idle_timeout`, go to DONE without recording.
  - DONE: sets `done`; stays until `enable` falls.
- Rising edge of `enable`: clears `symbol_count`, `done` and `overflow`, then enters ARMED. Memory is not cleared.
- Falling edge of `enable` in any state: enter IDLE next cycle. `symbol_count`, flags and memory are retained for readout.
- `busy` = ARMED or MEASURE.
- Config writes during MEASURE take effect immediately; software must not change `pin_sel` mid-capture.

## Timing
- Reset values: all registers 0, FSM in IDLE, `uo_out`=0, `data_out`=0, `user_interrupt`=0. Memory contents are undefined after reset.
- Edge detection: `lvl` is registered as `prev_lvl`; the edge is seen in the cycle where `lvl != prev_lvl`.
- Symbol write latency: the memory write, `symbol_count` increment and `dur` reset happen on the clock edge ending the detect cycle. The value is readable 1 cycle after the edge is detected.
- `done`, and `user_interrupt` if enabled, rise in the same cycle as the final write or the timeout.
- Simultaneous set and clear of `done`: set wins.
- Tick and edge in the same cycle: the edge wins and the tick is discarded.
- Reads: `data_out` reflects the currently addressed location combinationally. Unmapped addresses read 0.
- Reset asserted mid-capture: IDLE next cycle.

## Structure
- Shared package `pulse_transmitter_pkg` holds:
  - Register offsets (`REG_CFG`, `REG_THR`, `REG_STATUS`, `DATA_BASE`).
  - CFG field bit positions.
  - Symbol encoding constants (`SYM_LOW_A`…`SYM_HIGH_B`), shared with the transmitter.
  - FSM state typedef.
- One sub-module, `pulse_receiver_duration_counter`:
  - Contains the prescaler plus the saturating 8-bit duration counter.
  - Inputs: `clear`, `prescaler`.
  - Outputs: `dur`, `saturated`.

## Test plan
- P=0, thresholds 10/10, `last_index`=3. Drive high 5, low 20, high 15, low 3 clk, then high → word0[7:0]=`8'b00_11_01_10`, `symbol_count`=4, `done`=1, irq=1 if `irq_en`.
- P=2, `idle_timeout`=4. One high pulse of 40 clk, then idle → 1 symbol, `done` asserted 16 clk after the falling edge, no low symbol recorded.
- High pulse of 300 clk, P=0 → `overflow`=1, symbol=2'b11.
- `last_index`=20, 21 alternating 3-clk pulses → word1[9:8] written, `symbol_count`=21, later edges ignored.
- Write STATUS bit8=1 in the same cycle the final symbol is written → `done` stays 1. A clear on a later cycle drops `done` and the irq.
- `enable`→0 mid-MEASURE after 5 symbols → IDLE and `symbol_count`=5 retained. Re-enable → count 0, ARMED.

Source files
------------

// File: rtl/pulse_transmitter_pkg.sv
// Shared definitions for the pulse transmitter/receiver pair: register map,
// CFG field positions, 2-bit symbol encoding and receiver FSM states.
package pulse_transmitter_pkg;

  localparam logic [5:0] REG_CFG    = 6'h00;
  localparam logic [5:0] REG_THR    = 6'h04;
  localparam logic [5:0] REG_STATUS = 6'h08;
  localparam logic [5:0] DATA_BASE  = 6'h20;

  localparam int CFG_EN       = 0;
  localparam int CFG_PIN_LSB  = 1;
  localparam int CFG_INV      = 4;
  localparam int CFG_IRQ      = 5;
  localparam int CFG_PRE_LSB  = 6;
  localparam int CFG_TMO_LSB  = 10;
  localparam int CFG_LAST_LSB = 18;
  localparam int CFG_W        = 25;

  localparam int STAT_DONE_CLR = 8;

  // {level, long}: bit1 is the pulse level, bit0 set when above threshold
  localparam logic [1:0] SYM_LOW_A  = 2'b00;
  localparam logic [1:0] SYM_LOW_B  = 2'b01;
  localparam logic [1:0] SYM_HIGH_A = 2'b10;
  localparam logic [1:0] SYM_HIGH_B = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ARMED, ST_MEASURE, ST_DONE
  } rx_state_e;

endpackage

// File: rtl/pulse_receiver_duration_counter.sv
// Prescaled tick generator feeding a saturating 8-bit pulse duration counter.
module pulse_receiver_duration_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic [3:0] prescaler_i,
  output logic       tick_o,
  output logic [7:0] dur_o,
  output logic       saturated_o
);

  logic [14:0] pre_q;
  logic [7:0]  dur_q;
  logic [14:0] mask;

  assign mask = 15'((16'd1 << prescaler_i) - 16'd1);
  // >= keeps the period bounded if P is lowered while the counter is high
  assign tick_o      = (pre_q >= mask);
  assign dur_o       = dur_q;
  assign saturated_o = (dur_q == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      pre_q <= '0;
      dur_q <= '0;
    end else if (tick_o) begin
      pre_q <= '0;
      if (!saturated_o) dur_q <= dur_q + 8'd1;
    end else begin
      pre_q <= pre_q + 15'd1;
    end
  end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV pulse receiver: classifies captured pulses into 2-bit symbols packed
// into a word memory readable over the peripheral bus.
module tqvp_hx2003_pulse_receiver
  import pulse_transmitter_pkg::*;
#(
  parameter int NUM_DATA_REG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic [CFG_W-1:0] cfg_q;
  logic [15:0]      thr_q;
  rx_state_e        state_q, state_d;
  logic [6:0]       count_q, count_d;
  logic             done_q, done_d, ovf_q, ovf_d;
  logic             prev_lvl_q;
  logic [NUM_DATA_REG-1:0][31:0] mem_q;

  logic       enable, invert, irq_en;
  logic [2:0] pin_sel;
  logic [3:0] prescaler;
  logic [7:0] tmo;
  logic [6:0] last_idx;
  logic       lvl, edge_det, tick, saturated, tmo_hit, arm, rec;
  logic [7:0] dur, thr_sel;
  logic [8:0] tmo_full;
  logic [1:0] sym;
  logic       wr_en, done_clr, busy;
  logic       unused_ok;

  assign enable    = cfg_q[CFG_EN];
  assign pin_sel   = cfg_q[CFG_PIN_LSB +: 3];
  assign invert    = cfg_q[CFG_INV];
  assign irq_en    = cfg_q[CFG_IRQ];
  assign prescaler = cfg_q[CFG_PRE_LSB +: 4];
  assign tmo       = cfg_q[CFG_TMO_LSB +: 8];
  assign last_idx  = cfg_q[CFG_LAST_LSB +: 7];

  assign lvl      = ui_in[pin_sel] ^ invert;
  assign edge_det = (lvl != prev_lvl_q);

  pulse_receiver_duration_counter u_dur (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (edge_det | arm),
    .prescaler_i (prescaler),
    .tick_o      (tick),
    .dur_o       (dur),
    .saturated_o (saturated)
  );

  // Timeout fires on the tick that would bring dur up to the limit; 0 = 256
  assign tmo_full = (tmo == 8'd0) ? 9'd256 : {1'b0, tmo};
  assign tmo_hit  = tick && (({1'b0, dur} + 9'd1) == tmo_full);
  assign thr_sel  = prev_lvl_q ? thr_q[15:8] : thr_q[7:0];
  assign sym      = prev_lvl_q ? ((dur > thr_sel) ? SYM_HIGH_B : SYM_HIGH_A)
                               : ((dur > thr_sel) ? SYM_LOW_B  : SYM_LOW_A);

  assign wr_en    = (data_write_n == 2'b10) && !address[5];
  assign done_clr = wr_en && (address[3:2] == REG_STATUS[3:2]) && data_in[STAT_DONE_CLR];
  assign busy     = (state_q == ST_ARMED) || (state_q == ST_MEASURE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q & ~done_clr;
    ovf_d   = ovf_q;
    arm     = 1'b0;
    rec     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          arm     = 1'b1;
          count_d = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
        ST_ARMED: if (edge_det && lvl) state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (saturated && lvl && prev_lvl_q) ovf_d = 1'b1;
          if (edge_det) begin
            rec     = 1'b1;
            count_d = count_q + 7'd1;
            if (count_q == last_idx) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else if (!lvl && tmo_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      prev_lvl_q <= 1'b0;
      cfg_q      <= '0;
      thr_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      prev_lvl_q <= lvl;
      if (wr_en && address[3:2] == REG_CFG[3:2]) cfg_q <= data_in[CFG_W-1:0];
      if (wr_en && address[3:2] == REG_THR[3:2]) thr_q <= data_in[15:0];
    end
  end

  // Symbol memory is left unreset; results stay readable across captures
  always_ff @(posedge clk) begin
    if (rec && (int'(count_q[6:4]) < NUM_DATA_REG))
      mem_q[count_q[6:4]][{count_q[3:0], 1'b0} +: 2] <= sym;
  end

  always_comb begin
    data_out = '0;
    if (address[5]) begin
      if (int'(address[4:2]) < NUM_DATA_REG) data_out = mem_q[address[4:2]];
    end else begin
      case (address[3:2])
        REG_CFG[3:2]:    data_out = {{(32-CFG_W){1'b0}}, cfg_q};
        REG_THR[3:2]:    data_out = {16'd0, thr_q};
        REG_STATUS[3:2]: data_out = {20'd0, lvl, busy, ovf_q, done_q, 1'b0, count_q};
        default:         data_out = '0;
      endcase
    end
  end

  assign uo_out         = 8'd0;
  assign data_ready     = 1'b1;
  assign user_interrupt = done_q & irq_en;
  assign unused_ok      = ^{data_read_n, address[1:0], data_in[31:CFG_W], DATA_BASE};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Self-checking bench: register vectors, directed capture scenarios and
// random pulse trains checked against a pulse-length based reference model.
module tb_tqvp_hx2003_pulse_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in, uo_out;
  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;

  always #5 clk = ~clk;

  tqvp_hx2003_pulse_receiver #(.NUM_DATA_REG(8)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  wn;
    logic [31:0] wd;
    logic [5:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int pin = 0;
  bit inv = 0;
  int pq[$];
  logic [1:0] es[$];
  bit eovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic set_lvl(input bit l);
    logic [7:0] v;
    v = 8'($urandom);
    v[pin] = l ^ inv;
    ui_in = v;
  endtask

  function automatic logic [31:0] cfgw(bit en, int p, int tmo, int last, bit irq);
    logic [31:0] c;
    c = '0;
    c[0] = en; c[3:1] = 3'(pin); c[4] = inv; c[5] = irq;
    c[9:6] = 4'(p); c[17:10] = 8'(tmo); c[24:18] = 7'(last);
    return c;
  endfunction

  task automatic setup(input int p, input int lo, input int hi, input int last,
                       input int tmo, input bit irq);
    wr(6'h00, cfgw(0, p, tmo, last, irq), 2'b10);
    wr(6'h04, {16'd0, 8'(hi), 8'(lo)}, 2'b10);
    set_lvl(0);
    cyc(2);
    wr(6'h00, cfgw(1, p, tmo, last, irq), 2'b10);
    cyc(2);
  endtask

  // Reference: pulse i (high when i even) of L clocks ends with dur=(L-1)>>P;
  // a low pulse longer than timeout<<P ends the capture unrecorded.
  function automatic void run_model(int p, int lo, int hi, int last, int tmo);
    int tfull, d, l;
    bit lv;
    es.delete();
    eovf = 0;
    tfull = (tmo == 0) ? 256 : tmo;
    foreach (pq[i]) begin
      lv = (i % 2 == 0);
      l  = pq[i];
      if (!lv && (i == pq.size() - 1 || l > (tfull << p))) break;
      if (lv && l >= 2 && ((l - 2) >> p) >= 255) eovf = 1;
      d = (l - 1) >> p;
      if (d > 255) d = 255;
      es.push_back({lv, (d > (lv ? hi : lo))});
      if (es.size() == last + 1) break;
    end
  endfunction

  task automatic run_train(input string tag, input int p, input int lo, input int hi,
                           input int last, input int tmo, input bit irq);
    logic [31:0] st, v;
    logic [31:0] ew[8], em[8];
    bit got;
    int tfull;
    tfull = (tmo == 0) ? 256 : tmo;
    setup(p, lo, hi, last, tmo, irq);
    foreach (pq[i]) begin
      set_lvl(i % 2 == 0);
      cyc(pq[i]);
    end
    set_lvl(0);
    got = 0;
    st  = '0;
    for (int w = 0; w < (tfull << p) + 40 && !got; w++) begin
      rd(6'h08, st);
      if (st[8]) got = 1;
      else cyc(1);
    end
    run_model(p, lo, hi, last, tmo);
    chk({tag, " status"}, st, {20'd0, 1'b0, 1'b0, eovf, 1'b1, 1'b0, 7'(es.size())});
    chk({tag, " irq"}, {31'd0, user_interrupt}, {31'd0, irq});
    for (int w = 0; w < 8; w++) begin ew[w] = '0; em[w] = '0; end
    foreach (es[k]) begin
      ew[k / 16][2 * (k % 16) +: 2] = es[k];
      em[k / 16][2 * (k % 16) +: 2] = 2'b11;
    end
    for (int w = 0; w < 8; w++) begin
      if (em[w] != 0) begin
        rd(6'(32 + 4 * w), v);
        chk($sformatf("%s word%0d", tag, w), v & em[w], ew[w]);
      end
    end
  endtask

  initial begin
    vec_t vt[11];
    logic [31:0] v;
    int p, lo, hi, last, tmo, n;
    bit irq;

    rst_n = 0; ui_in = '0; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    cyc(3);
    rst_n = 1;
    cyc(1);

    // reset state
    rd(6'h00, v);
    chk("reset data_out", v, 32'd0);
    chk("reset uo_out", {24'd0, uo_out}, 32'd0);
    chk("reset irq", {31'd0, user_interrupt}, 32'd0);
    chk("data_ready", {31'd0, data_ready}, 32'd1);
    rd(6'h08, v);
    chk("reset status", v, 32'd0);

    // register access vectors (ui_in held at 0)
    vt[0]  = '{6'h00, 2'b10, 32'h01FF_FFFE, 6'h00, 32'h01FF_FFFE};
    vt[1]  = '{6'h04, 2'b10, 32'hFFFF_1234, 6'h04, 32'h0000_1234};
    vt[2]  = '{6'h04, 2'b01, 32'h0000_ABCD, 6'h04, 32'h0000_1234};
    vt[3]  = '{6'h04, 2'b00, 32'h0000_5555, 6'h04, 32'h0000_1234};
    vt[4]  = '{6'h00, 2'b11, 32'h0,         6'h07, 32'h0000_1234};
    vt[5]  = '{6'h00, 2'b11, 32'h0,         6'h0C, 32'h0};
    vt[6]  = '{6'h00, 2'b11, 32'h0,         6'h08, 32'h0000_0800};
    vt[7]  = '{6'h08, 2'b10, 32'hFFFF_FFFF, 6'h08, 32'h0000_0800};
    vt[8]  = '{6'h00, 2'b10, 32'h0000_0000, 6'h08, 32'h0};
    vt[9]  = '{6'h00, 2'b10, 32'h0000_0010, 6'h00, 32'h0000_0010};
    vt[10] = '{6'h00, 2'b10, 32'h0000_0000, 6'h00, 32'h0};
    for (int i = 0; i < 11; i++) begin
      if (vt[i].wn != 2'b11) wr(vt[i].addr, vt[i].wd, vt[i].wn);
      rd(vt[i].raddr, v);
      chk($sformatf("vec%0d", i), v, vt[i].exp);
    end

    // basic four-symbol capture, done by count
    pin = 0; inv = 0;
    pq = '{5, 20, 15, 3, 4};
    run_train("t1", 0, 10, 10, 3, 0, 1);
    rd(6'h20, v);
    chk("t1 word0[7:0]", {24'd0, v[7:0]}, 32'h36);

    // idle timeout: detected falling edge, then done 16 clocks later
    pin = 3; inv = 1;
    setup(2, 5, 5, 10, 4, 1);
    set_lvl(1); cyc(40);
    set_lvl(0); cyc(16);
    rd(6'h08, v);
    chk("t2 done early", {31'd0, v[8]}, 32'd0);
    cyc(1);
    rd(6'h08, v);
    chk("t2 status", v, 32'h0000_0101);
    chk("t2 irq", {31'd0, user_interrupt}, 32'd1);
    rd(6'h20, v);
    chk("t2 sym", {30'd0, v[1:0]}, 32'd3);

    // high pulse saturates the duration counter
    pin = 1; inv = 0;
    pq = '{300, 5};
    run_train("t3", 0, 10, 10, 0, 0, 0);

    // 21 short pulses, later edges ignored
    pin = 5;
    pq.delete();
    for (int i = 0; i < 25; i++) pq.push_back(3);
    run_train("t4", 0, 1, 5, 20, 0, 1);
    rd(6'h24, v);
    chk("t4 word1[9:8]", {30'd0, v[9:8]}, 32'd2);

    // done clear coinciding with the final write: set wins
    pin = 2;
    setup(0, 10, 10, 0, 0, 1);
    set_lvl(1); cyc(5);
    set_lvl(0);
    address = 6'h08; data_in = 32'h100; data_write_n = 2'b10;
    cyc(1);
    data_write_n = 2'b11;
    rd(6'h08, v);
    chk("t5 done kept", {31'd0, v[8]}, 32'd1);
    chk("t5 irq kept", {31'd0, user_interrupt}, 32'd1);
    wr(6'h08, 32'h100, 2'b10);
    rd(6'h08, v);
    chk("t5 done cleared", {31'd0, v[8]}, 32'd0);
    chk("t5 irq cleared", {31'd0, user_interrupt}, 32'd0);

    // disable mid-capture keeps results; re-enable clears and arms
    pin = 6; inv = 0;
    setup(0, 10, 10, 20, 0, 0);
    for (int i = 0; i < 5; i++) begin set_lvl(i % 2 == 0); cyc(3); end
    set_lvl(0); cyc(2);
    wr(6'h00, cfgw(0, 0, 0, 20, 0), 2'b10);
    cyc(1);
    rd(6'h08, v);
    chk("t6 idle count", v, 32'h0000_0005);
    wr(6'h00, cfgw(1, 0, 0, 20, 0), 2'b10);
    cyc(1);
    rd(6'h08, v);
    chk("t6 rearmed", v, 32'h0000_0400);
    set_lvl(1); cyc(2);
    ui_in = '0;
    rst_n = 0; cyc(1); rst_n = 1;
    rd(6'h08, v);
    chk("t6 reset status", v, 32'd0);
    rd(6'h00, v);
    chk("t6 reset cfg", v, 32'd0);

    // random trains against the model
    for (int it = 0; it < 10; it++) begin
      pin  = $urandom_range(0, 7);
      inv  = 1'($urandom_range(0, 1));
      p    = $urandom_range(0, 2);
      lo   = $urandom_range(0, 15);
      hi   = $urandom_range(0, 15);
      last = $urandom_range(2, 12);
      tmo  = $urandom_range(10, 40);
      irq  = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 16);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back($urandom_range(1, 24));
      run_train($sformatf("rnd%0d", it), p, lo, hi, last, tmo, irq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
